// File: rtl/sine_voice_pkg.sv
// Shared widths, FSM encoding and quadrant helpers for the sine voice bank.
// Defaults here describe the standard 3-voice, 16-bit codec configuration.
package sine_voice_pkg;

  localparam int NV_DEF        = 3;
  localparam int STEP_INT_DEF  = 10;
  localparam int STEP_FRAC_DEF = 10;
  localparam int ROM_AW_DEF    = 10;
  localparam int SMP_W         = 16;

  localparam int STEP_W = STEP_INT_DEF + STEP_FRAC_DEF;
  localparam int PH_W   = 2 + ROM_AW_DEF + STEP_FRAC_DEF;
  localparam int ACC_W  = SMP_W + $clog2(NV_DEF) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  function automatic logic signed [SMP_W-1:0] quad_map(
    input logic [1:0]       q,
    input logic [SMP_W-1:0] d
  );
    quad_map = q[1] ? -$signed(d) : $signed(d);
  endfunction

  // Quarter-wave table: parabolic fit reaching full scale at the last entry.
  function automatic logic [SMP_W-1:0] rom_entry(
    input int aw,
    input int idx
  );
    longint n, amp, v;
    n   = (longint'(1) << aw) - 1;
    amp = (longint'(1) << (SMP_W - 1)) - 1;
    v   = amp * longint'(idx) * (2 * n - longint'(idx)) / (n * n);
    return v[SMP_W-1:0];
  endfunction

endpackage

// File: rtl/sine_quarter_lookup.sv
// Quarter-wave ROM with quadrant address mirror and sign stage.
// One cycle from phase in to signed sample out.
module sine_quarter_lookup
  import sine_voice_pkg::*;
#(
  parameter int ROM_ADDR_W = ROM_AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROM_ADDR_W+1:0]   phase,
  output logic signed [SMP_W-1:0] data
);

  logic [SMP_W-1:0]      rom [2**ROM_ADDR_W];
  logic [1:0]            quad;
  logic [1:0]            quad_q;
  logic [ROM_ADDR_W-1:0] addr;
  logic [ROM_ADDR_W-1:0] mirror;
  logic [SMP_W-1:0]      rom_q;

  for (genvar i = 0; i < 2**ROM_ADDR_W; i++) begin : g_rom
    localparam logic [SMP_W-1:0] V = rom_entry(ROM_ADDR_W, i);
    assign rom[i] = V;
  end

  assign quad   = phase[ROM_ADDR_W+1 -: 2];
  assign addr   = phase[ROM_ADDR_W-1:0];
  assign mirror = quad[0] ? ~addr : addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q  <= '0;
      quad_q <= '0;
    end else begin
      rom_q  <= rom[mirror];
      quad_q <= quad;
    end
  end

  assign data = quad_map(quad_q, rom_q);

endmodule

// File: rtl/sine_voice_bank.sv
// Multi-voice sine generator: per-voice phase accumulators sharing one
// quarter-wave lookup, mixed with saturation into one sample per request.
module sine_voice_bank
  import sine_voice_pkg::*;
#(
  parameter int NUM_VOICES  = NV_DEF,
  parameter int STEP_INT_W  = STEP_INT_DEF,
  parameter int STEP_FRAC_W = STEP_FRAC_DEF,
  parameter int ROM_ADDR_W  = ROM_AW_DEF,
  parameter int SAMPLE_W    = SMP_W
) (
  input  logic clk,
  input  logic reset,
  input  logic [NUM_VOICES*(STEP_INT_W+STEP_FRAC_W)-1:0] step_size,
  input  logic [NUM_VOICES-1:0] voice_en,
  input  logic generate_next,
  output logic sample_ready,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic busy,
  output logic overrun
);

  // Package widths are the defaults; shift them by any parameter override.
  localparam int SW = STEP_W + (STEP_INT_W - STEP_INT_DEF)
                    + (STEP_FRAC_W - STEP_FRAC_DEF);
  localparam int PW = PH_W + (ROM_ADDR_W - ROM_AW_DEF)
                    + (STEP_FRAC_W - STEP_FRAC_DEF);
  localparam int AW = ACC_W + (SAMPLE_W - SMP_W)
                    + ($clog2(NUM_VOICES) - $clog2(NV_DEF));
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RW = 2 + ROM_ADDR_W;

  localparam logic signed [AW-1:0] S_MAX = AW'(2**(SAMPLE_W-1) - 1);
  localparam logic signed [AW-1:0] S_MIN = ~S_MAX;

  state_t                     state;
  logic [VW-1:0]              v;
  logic signed [AW-1:0]       acc;
  logic [PW-1:0]              phase [NUM_VOICES];
  logic                       gen_prev;
  logic                       start;
  logic [SW-1:0]              cur_step;
  logic                       cur_en;
  logic signed [SAMPLE_W-1:0] voice_data;
  logic signed [AW-1:0]       voice_ext;
  logic signed [SAMPLE_W-1:0] sat;

  assign start     = generate_next & ~gen_prev;
  assign cur_step  = step_size[v*SW +: SW];
  assign cur_en    = voice_en[v];
  assign voice_ext = {{(AW-SAMPLE_W){voice_data[SAMPLE_W-1]}}, voice_data};

  sine_quarter_lookup #(
    .ROM_ADDR_W(ROM_ADDR_W)
  ) u_lookup (
    .clk  (clk),
    .rst_n(reset),
    .phase(phase[v][PW-1 -: RW]),
    .data (voice_data)
  );

  always_comb begin
    sat = acc[SAMPLE_W-1:0];
    if (acc > S_MAX)
      sat = S_MAX[SAMPLE_W-1:0];
    else if (acc < S_MIN)
      sat = S_MIN[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      v            <= '0;
      acc          <= '0;
      gen_prev     <= 1'b0;
      sample       <= '0;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++)
        phase[i] <= '0;
    end else begin
      gen_prev     <= generate_next;
      sample_ready <= 1'b0;
      if (start && state != S_IDLE)
        overrun <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ADDR;
            v     <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        S_ADDR: state <= S_DATA;
        S_DATA: begin
          // Disabled voices park at phase 0 so re-enabling restarts them.
          if (cur_en) begin
            acc      <= acc + voice_ext;
            phase[v] <= phase[v] + PW'(cur_step);
          end else begin
            phase[v] <= '0;
          end
          if (v == VW'(NUM_VOICES-1)) begin
            state <= S_DONE;
          end else begin
            v     <= v + 1'b1;
            state <= S_ADDR;
          end
        end
        S_DONE: begin
          sample       <= sat;
          sample_ready <= 1'b1;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_voice_bank.sv
// Bench for sine_voice_bank: cycle compare against a request-level model
// plus directed literal sample values.
module tb_sine_voice_bank;

  localparam int NV = 3;
  localparam int SW = 20;

  logic                 clk = 0;
  logic                 rst_n = 0;
  logic                 gen = 0;
  logic [NV*SW-1:0]     step = '0;
  logic [NV-1:0]        en = '0;
  logic                 rdy;
  logic                 busy;
  logic                 ovr;
  logic signed [15:0]   smp;

  int n_checks = 0;
  int n_pass = 0;
  int rdy_cnt = 0;
  bit chk_on = 0;

  int ph_m [NV];
  int pend = 0;
  int val_m = 0;
  int exp_smp = 0;
  int sum_m = 0;
  bit gp_m = 0;
  bit st_m = 0;
  bit exp_rdy = 0;
  bit exp_ovr = 0;

  sine_voice_bank dut (
    .clk          (clk),
    .reset        (rst_n),
    .step_size    (step),
    .voice_en     (en),
    .generate_next(gen),
    .sample_ready (rdy),
    .sample       (smp),
    .busy         (busy),
    .overrun      (ovr)
  );

  always #5 clk = ~clk;

  function automatic int rom_m(input int i);
    longint p;
    p = longint'(32767) * i * (2046 - i);
    return int'(p / 1046529);
  endfunction

  function automatic int voice_m(input int ph);
    int q, a, m;
    q = (ph >> 20) & 3;
    a = (ph >> 10) & 1023;
    m = (q % 2 == 1) ? 1023 - a : a;
    return (q >= 2) ? -rom_m(m) : rom_m(m);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Request-level model: one start -> full mix result 2*NV+1 edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (ph_m[i]) ph_m[i] = 0;
      pend = 0;
      exp_smp = 0;
      gp_m = 0;
      exp_rdy = 0;
      exp_ovr = 0;
    end else begin
      st_m = gen && !gp_m;
      gp_m = gen;
      exp_rdy = 0;
      if (pend > 0) begin
        if (st_m) exp_ovr = 1;
        pend--;
        if (pend == 0) begin
          exp_rdy = 1;
          exp_smp = val_m;
        end
      end else if (st_m) begin
        sum_m = 0;
        for (int i = 0; i < NV; i++) begin
          if (en[i]) begin
            sum_m += voice_m(ph_m[i]);
            ph_m[i] = (ph_m[i] + int'(step[i*SW +: SW])) & 32'h3FFFFF;
          end else begin
            ph_m[i] = 0;
          end
        end
        if (sum_m > 32767) sum_m = 32767;
        if (sum_m < -32768) sum_m = -32768;
        val_m = sum_m;
        pend = 2 * NV + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ready", int'(rdy), int'(exp_rdy));
      chk("busy", int'(busy), (pend > 0) ? 1 : 0);
      chk("overrun", int'(ovr), int'(exp_ovr));
      chk("sample", int'(smp), exp_smp);
      if (rdy) rdy_cnt++;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic req(input bit lit, input int exp, input string nm);
    bit got;
    int lat;
    got = 0;
    lat = -1;
    @(negedge clk);
    gen = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) gen = 0;
      if (rdy) begin
        got = 1;
        lat = k - 1;
        if (lit) chk({nm, " value"}, int'(smp), exp);
        break;
      end
    end
    chk({nm, " latency"}, lat, 7);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [NV*SW-1:0] steps(input int s2, input int s1,
                                             input int s0);
    return {SW'(s2 << 10), SW'(s1 << 10), SW'(s0 << 10)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp2 [9];
    int exp3 [8];
    exp2 = '{0, 24591, 32767, 24559, 0, -24591, -32767, -24559, 0};
    exp3 = '{0, 32767, 32767, 32767, 0, -32768, -32768, -32768};

    repeat (2) @(negedge clk);
    chk("reset ready", int'(rdy), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset overrun", int'(ovr), 0);
    chk("reset sample", int'(smp), 0);
    chk_on = 1;
    rst_n = 1;
    @(negedge clk);

    // all voices off
    step = steps(512, 512, 512);
    en = 3'b000;
    req(1, 0, "all off");

    // voice 0 walks the four quadrants and wraps
    step = steps(0, 0, 512);
    en = 3'b001;
    for (int i = 0; i < 9; i++)
      req(1, exp2[i], $sformatf("v0 req%0d", i));

    // three voices together saturate both ways
    do_reset();
    step = steps(512, 512, 512);
    en = 3'b111;
    for (int i = 0; i < 8; i++)
      req(1, exp3[i], $sformatf("sat req%0d", i));

    // held level gives one request
    @(negedge clk);
    rdy_cnt = 0;
    gen = 1;
    repeat (30) @(negedge clk);
    gen = 0;
    repeat (5) @(negedge clk);
    chk("held strobes", rdy_cnt, 1);

    // second edge 3 cycles after start is dropped
    rdy_cnt = 0;
    @(negedge clk);
    gen = 1;
    @(negedge clk);
    gen = 0;
    @(negedge clk);
    @(negedge clk);
    gen = 1;
    @(negedge clk);
    gen = 0;
    repeat (15) @(negedge clk);
    chk("overrun strobes", rdy_cnt, 1);
    chk("overrun sticky", int'(ovr), 1);

    // reset during ADDR of voice 1
    step = steps(0, 0, 512);
    en = 3'b001;
    rdy_cnt = 0;
    @(negedge clk);
    gen = 1;
    @(negedge clk);
    gen = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("mid reset strobes", rdy_cnt, 0);
    chk("mid reset sample", int'(smp), 0);
    chk("mid reset overrun", int'(ovr), 0);
    req(1, 0, "post reset req0");
    req(1, 24591, "post reset req1");

    // voice 1 disabled then re-enabled restarts from phase 0
    do_reset();
    step = steps(128, 512, 128);
    en = 3'b111;
    req(1, 0, "toggle req0");
    en = 3'b101;
    req(1, 15372, "toggle req1");
    en = 3'b111;
    req(1, 28694, "toggle req2");
    req(0, 0, "toggle req3");

    repeat (5) @(negedge clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sine_voice_bank.md
Name: sine_voice_bank

Overview:
- Parametrised successor to the single-voice sine reader. Generates NUM_VOICES independent sine tones, each with its own fixed-point step size and phase accumulator.
- All voices share one quarter-wave ROM, time-multiplexed.
- Voices are summed with saturation into one signed sample per generate_next request.
- Sits between the note/step controller and the codec sample path.

Parameters:
- NUM_VOICES, 3, number of voices (1..8)
- STEP_INT_W, 10, integer bits of step_size per voice
- STEP_FRAC_W, 10, fractional bits of step_size per voice
- ROM_ADDR_W, 10, quarter-wave ROM address width (2^ROM_ADDR_W entries)
- SAMPLE_W, 16, signed sample width (ROM and output)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- step_size  input  NUM_VOICES*(STEP_INT_W+STEP_FRAC_W)  flattened per-voice step; voice v occupies slice v
- voice_en  input  NUM_VOICES  per-voice enable
- generate_next  input  1  sample request; may be a pulse or held high
- sample_ready  output  1  one-cycle strobe: sample just updated
- sample  output  SAMPLE_W  signed mixed sample, held between strobes
- busy  output  1  high while a request is being processed
- overrun  output  1  sticky: a request arrived while busy

Behaviour:
- Reset (reset low, async): every phase = 0, sample = 0, sample_ready = 0, busy = 0, overrun = 0, FSM = IDLE, gen_prev = 0.
- Phase accumulator per voice:
  - Width PH_W = 2 + ROM_ADDR_W + STEP_FRAC_W = 22 at defaults.
  - Field layout: quadrant = phase[PH_W-1 -: 2]; addr = next ROM_ADDR_W bits; remaining bits are fraction.
  - Step is zero-extended to PH_W before add.
  - Wrap-around is modulo 2^PH_W, with no flag.
- Request detection:
  - A start occurs on a clock edge where generate_next = 1 and gen_prev = 0. gen_prev registers generate_next every cycle.
  - A level held high therefore yields exactly one start.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE -> ADDR on start. Voice index v = 0; accumulator = 0; busy = 1.
  - ADDR(v): present the ROM address for voice v. ROM is synchronous, 1-cycle latency.
  - DATA(v):
    - Apply the quadrant map to the ROM data:
      - q0: +rom[addr]
      - q1: +rom[~addr]
      - q2: -rom[addr]
      - q3: -rom[~addr]
    - If voice_en[v], add the mapped value to the accumulator and advance phase_v += step_v. The sample uses the pre-advance phase.
    - If !voice_en[v], add 0 and clear phase_v to 0, so a re-enabled voice restarts at phase 0.
    - Next state: ADDR(v+1), or DONE if v = NUM_VOICES-1.
  - DONE: sample <= accumulator saturated to SAMPLE_W signed; sample_ready = 1 for this one cycle; busy = 0; -> IDLE.
- Accumulator width is SAMPLE_W + clog2(NUM_VOICES) + 1, signed.
- Negating the most negative value is never required; ROM entries are non-negative, at most 2^(SAMPLE_W-1)-1.
- Latency: sample_ready is high in cycle 2*NUM_VOICES+1 after the start edge (7 cycles at defaults). Minimum request period is 2*NUM_VOICES+2 cycles.
- Start while busy (FSM not IDLE): request dropped, overrun <= 1 (sticky until reset). A start coincident with DONE is also dropped.
- step_size and voice_en are sampled live in each voice's DATA cycle. Changes mid-request affect only voices not yet processed.
- Reset asserted mid-request: immediate return to the reset state. No sample_ready is issued.

Decomposition:
- Package sine_voice_pkg holds:
  - localparams PH_W, ACC_W, STEP_W
  - FSM state encoding (IDLE, ADDR, DATA, DONE)
  - the quadrant map function, which returns signed SAMPLE_W data
- Sub-module sine_quarter_lookup wraps the existing quarter-wave ROM with the quadrant address mirror and sign stage: 1-cycle latency, input phase, output signed sample.
- Phase registers, FSM, mixer and saturation stay in the top module.

Test Plan:
- All voice_en = 0, one generate_next pulse -> sample_ready 7 cycles after the start edge; sample = 0; all phases stay 0.
- Voice 0 only, step = {10'd512, 10'd0}, 8 requests -> samples are rom[0], rom[512], rom[1023], rom[511], -rom[0], -rom[512], -rom[1023], -rom[511]; the 9th request repeats rom[0] (wrap).
- Three voices each at phase for rom[1023] = 32767 -> sample saturates to 32767. Mirror test: all in q3 saturates to -32768.
- generate_next held high for 30 cycles -> exactly one sample_ready. A second rising edge 3 cycles after start -> dropped, overrun = 1, and exactly one sample_ready from the first request.
- reset pulsed low during ADDR of voice 1 -> no sample_ready. After release, sample = 0 and phases = 0. The next request yields rom[0] per enabled voice.
- voice_en[1] toggled 1 -> 0 -> 1 across requests -> voice 1 restarts from phase 0. Voices 0 and 2 continue uninterrupted.
